lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Multi-cycle load/store unit that replaces the purely combinational LSU. It takes one RV32I load/store per start pulse and computes the effective address. It drives a word-aligned request/grant/response memory bus with byte enables, and returns sign/zero-extended load data with a one-cycle done pulse. It adds misalignment faults and a bus timeout. It sits between decode/regfile and the data memory or bus bridge, and stalls the core via busy.

Parameters:
ADDR_W, 32, effective/bus address width; address arithmetic wraps modulo 2^ADDR_W.
TIMEOUT, 255, max cycles spent in REQ+RESP before abort; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  issue strobe; sampled only in IDLE
instr  in  rv32i_instr_e  operation (LB/LH/LW/LBU/LHU/SB/SH/SW; others ignored)
rs1  in  32  base register
rs2  in  32  store source
imm  in  32  offset, already sign-extended
busy  out  1  1 in every state except IDLE
done  out  1  one-cycle completion pulse (success, fault or timeout)
mem_wb_en  out  1  done & load & no error
mem_wb  out  32  extended load result; held until next done
fault_misaligned  out  1  qualified by done
fault_bus  out  1  qualified by done; timeout
fault_addr  out  ADDR_W  effective address of faulting op; qualified by done
mem_req  out  1  request valid
mem_we  out  1  1 = store
mem_addr  out  ADDR_W  word-aligned address (ea[1:0] forced to 00)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  response (load data or store ack)
mem_rdata  in  32  load word

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counter=0. All outputs 0, including mem_wb, fault_addr, mem_req, mem_be and mem_wdata. An in-flight transaction is abandoned without a done pulse.
- ea = rs1 + imm, truncated to ADDR_W. off = ea[1:0].
- Alignment rules:
  - H ops need off[0]=0.
  - W ops need off=00.
  - B ops are always aligned.
- States: IDLE, REQ, RESP, FIN.
- IDLE, start=1 with a memory instr:
  - Latch op, off, ea, be and wdata.
  - Misaligned: go to FIN with fault_misaligned pending. No bus request is issued.
  - Aligned: go to REQ.
- IDLE, start=1 with a non-memory instr: ignored; no done pulse.
- start is ignored whenever busy=1.
- REQ:
  - mem_req=1.
  - mem_addr, mem_we, mem_be and mem_wdata stay stable until the mem_gnt cycle.
  - On mem_gnt, go to RESP; mem_req drops the next cycle.
  - mem_rvalid is ignored in REQ. Memory must respond at least 1 cycle after gnt.
- RESP: wait for mem_rvalid.
  - On mem_rvalid for a load: register mem_wb from mem_rdata lane off.
    - LB/LBU use byte [8*off+7:8*off].
    - LH/LHU use half [16*off[1]+15:16*off[1]].
    - Sign- or zero-extend to 32.
  - On mem_rvalid for a store: ack only; mem_wb keeps its old value.
  - Then go to FIN.
- FIN: done=1 for exactly this cycle, with the fault flags and mem_wb_en valid. Then go to IDLE.
- Timeout (TIMEOUT>0):
  - The counter clears on entering REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT, go to FIN with fault_bus=1 and mem_req=0.
  - mem_gnt and mem_rvalid in that cycle are ignored.
  - A later stray rvalid is ignored in IDLE.
- Store formatting:
  - SB: be=0001<<off, wdata={4{rs2[7:0]}}.
  - SH: be=0011<<off, wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Loads: mem_we=0 and mem_be reflects the access size. Memory may return the full word regardless.
- Latency, aligned access with zero-wait gnt and rvalid one cycle after gnt:
  - start at cycle 0.
  - mem_req and mem_gnt at cycle 1.
  - mem_rvalid at cycle 2.
  - done at cycle 3.
  - Next start accepted at cycle 4.
- Misaligned access: done at cycle 1.
- fault_addr is updated only on fault.

Decomposition:
- Shared package instruction_utils gains:
  - lsu_state_e
  - mem_size_e (BYTE=00, HALF=01, WORD=10)
  - functions is_load(instr), is_store(instr), size_of(instr), is_unsigned(instr)
- One combinational sub-module, lsu_align:
  - Inputs: size, unsigned flag, off, rs2, rdata.
  - Outputs: be, wdata, extended load result, misaligned.
  - It is reused by a future instruction-fetch path.

Test Plan:
- LB, rs1=0x100, imm=3, rdata=0x80_00_00_00 -> mem_addr=0x100, be=1000, done at cycle 3, mem_wb=0xFFFFFF80, mem_wb_en=1.
- LHU, ea=0x202, rdata=0xBEEF1234 -> mem_wb=0x0000BEEF. LH same -> 0xFFFFBEEF.
- SB, ea=0x301, rs2=0xAABBCCDD -> mem_we=1, mem_addr=0x300, be=0010, wdata=0xDDDDDDDD. mem_gnt held low 5 cycles -> mem_req and outputs stable throughout. done after rvalid, mem_wb_en=0.
- LW, ea=0x102 -> no mem_req, done at cycle 1, fault_misaligned=1, fault_addr=0x102. SH ea=0x101 -> same fault. SB ea=0x101 -> no fault.
- TIMEOUT=4, gnt never asserted -> mem_req high 4 cycles then low, done with fault_bus=1. A rvalid pulse afterwards causes no done.
- rst_n low in RESP -> busy=0, mem_req=0, mem_wb=0 immediately with no done. start during busy -> ignored, with exactly one done per accepted op.

Source files
------------

// File: rtl/instruction_utils.sv
// Shared RV32I decode helpers: instruction, LSU state and access-size types.
// Used by the load/store unit and the alignment datapath.
package instruction_utils;

  typedef enum logic [3:0] {
    I_NOP = 4'd0,
    I_LB  = 4'd1,
    I_LH  = 4'd2,
    I_LW  = 4'd3,
    I_LBU = 4'd4,
    I_LHU = 4'd5,
    I_SB  = 4'd6,
    I_SH  = 4'd7,
    I_SW  = 4'd8,
    I_ADD = 4'd9,
    I_BEQ = 4'd10
  } rv32i_instr_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_FIN  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  function automatic logic is_load(rv32i_instr_e i);
    return i inside {I_LB, I_LH, I_LW, I_LBU, I_LHU};
  endfunction

  function automatic logic is_store(rv32i_instr_e i);
    return i inside {I_SB, I_SH, I_SW};
  endfunction

  function automatic mem_size_e size_of(rv32i_instr_e i);
    mem_size_e s;
    s = WORD;
    if (i inside {I_LB, I_LBU, I_SB}) s = BYTE;
    if (i inside {I_LH, I_LHU, I_SH}) s = HALF;
    return s;
  endfunction

  function automatic logic is_unsigned(rv32i_instr_e i);
    return i inside {I_LBU, I_LHU};
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Word-aligned request/grant/response data bus with byte enables.
// master = load/store unit, slave = memory or bus bridge.
interface lsu_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_gnt,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_gnt,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extraction
// and sign/zero extension, plus the natural-alignment check.
module lsu_align
  import instruction_utils::*;
(
  input  mem_size_e   size_i,
  input  logic        uns_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misaligned_o
);

  logic [31:0] lane;

  // A halfword only reaches this path with off[0]=0, so the byte shift
  // also places the selected half in lane[15:0].
  assign lane = rdata_i >> {off_i, 3'b000};

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = '0;
    ldata_o      = '0;
    misaligned_o = 1'b0;
    unique case (1'b1)
      (size_i == BYTE): begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{rs2_i[7:0]}};
        ldata_o = uns_i ? {24'd0, lane[7:0]}
                        : {{24{lane[7]}}, lane[7:0]};
      end
      (size_i == HALF): begin
        be_o         = 4'b0011 << off_i;
        wdata_o      = {2{rs2_i[15:0]}};
        ldata_o      = uns_i ? {16'd0, lane[15:0]}
                             : {{16{lane[15]}}, lane[15:0]};
        misaligned_o = off_i[0];
      end
      default: begin
        be_o         = 4'b1111;
        wdata_o      = rs2_i;
        ldata_o      = rdata_i;
        misaligned_o = |off_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multi-cycle RV32I load/store unit: IDLE -> REQ -> RESP -> FIN,
// with misalignment faults and a REQ/RESP bus timeout.
module lsu_mem_ctrl
  import instruction_utils::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  rv32i_instr_e      instr,
  input  logic [31:0]       rs1,
  input  logic [31:0]       rs2,
  input  logic [31:0]       imm,
  output logic              busy,
  output logic              done,
  output logic              mem_wb_en,
  output logic [31:0]       mem_wb,
  output logic              fault_misaligned,
  output logic              fault_bus,
  output logic [ADDR_W-1:0] fault_addr,
  lsu_mem_ctrl_if.master    bus
);

  lsu_state_e        state_q;
  logic              load_q;
  logic              uns_q;
  mem_size_e         size_q;
  logic [1:0]        off_q;
  logic [ADDR_W-1:0] ea_q;
  logic [31:0]       cnt_q;
  logic              done_q;
  logic              wb_en_q;
  logic [31:0]       wb_q;
  logic              fmis_q;
  logic              fbus_q;
  logic [ADDR_W-1:0] faddr_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;

  logic [ADDR_W-1:0] ea;
  logic              idle;
  logic              mem_op;
  logic              tmo;
  mem_size_e         al_size;
  logic              al_uns;
  logic [1:0]        al_off;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_ldata;
  logic              al_mis;

  assign ea     = ADDR_W'(rs1 + imm);
  assign idle   = (state_q == S_IDLE);
  assign mem_op = is_load(instr) | is_store(instr);
  assign tmo    = (TIMEOUT != 0) && (cnt_q == 32'(TIMEOUT - 1));

  // One aligner: formats the incoming op in IDLE, extracts load data later.
  assign al_size = idle ? size_of(instr)     : size_q;
  assign al_uns  = idle ? is_unsigned(instr) : uns_q;
  assign al_off  = idle ? ea[1:0]            : off_q;

  lsu_align u_align (
    .size_i       (al_size),
    .uns_i        (al_uns),
    .off_i        (al_off),
    .rs2_i        (rs2),
    .rdata_i      (bus.mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .ldata_o      (al_ldata),
    .misaligned_o (al_mis)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      load_q  <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= BYTE;
      off_q   <= '0;
      ea_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wb_en_q <= 1'b0;
      wb_q    <= '0;
      fmis_q  <= 1'b0;
      fbus_q  <= 1'b0;
      faddr_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      done_q  <= 1'b0;
      wb_en_q <= 1'b0;
      fmis_q  <= 1'b0;
      fbus_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && mem_op) begin
            load_q  <= is_load(instr);
            uns_q   <= is_unsigned(instr);
            size_q  <= size_of(instr);
            off_q   <= ea[1:0];
            ea_q    <= ea;
            we_q    <= is_store(instr);
            addr_q  <= {ea[ADDR_W-1:2], 2'b00};
            be_q    <= al_be;
            wdata_q <= is_store(instr) ? al_wdata : '0;
            if (al_mis) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              fmis_q  <= 1'b1;
              faddr_q <= ea;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
              cnt_q   <= '0;
            end
          end
        end
        S_REQ: begin
          if (tmo) begin
            state_q <= S_FIN;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            fbus_q  <= 1'b1;
            faddr_q <= ea_q;
          end else begin
            cnt_q <= cnt_q + 32'd1;
            if (bus.mem_gnt) begin
              state_q <= S_RESP;
              req_q   <= 1'b0;
            end
          end
        end
        S_RESP: begin
          if (tmo) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            fbus_q  <= 1'b1;
            faddr_q <= ea_q;
          end else begin
            cnt_q <= cnt_q + 32'd1;
            if (bus.mem_rvalid) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
              wb_en_q <= load_q;
              if (load_q) wb_q <= al_ldata;
            end
          end
        end
        S_FIN: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy             = !idle;
  assign done             = done_q;
  assign mem_wb_en        = wb_en_q;
  assign mem_wb           = wb_q;
  assign fault_misaligned = fmis_q;
  assign fault_bus        = fbus_q;
  assign fault_addr       = faddr_q;

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_be    = be_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: vector table plus hand-written
// stall, timeout, busy-start and mid-transaction reset sequences.
module tb_lsu_mem_ctrl;
  import instruction_utils::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start_a, start_b;
  rv32i_instr_e instr;
  logic [31:0]  rs1, rs2, imm;

  logic        busy_a, done_a, wben_a, fmis_a, fbus_a;
  logic [31:0] wb_a, faddr_a;
  logic        busy_b, done_b, wben_b, fmis_b, fbus_b;
  logic [31:0] wb_b, faddr_b;

  lsu_mem_ctrl_if #(.ADDR_W(32)) bus_a ();
  lsu_mem_ctrl_if #(.ADDR_W(32)) bus_b ();

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(255)) dut (
    .clk (clk), .rst_n (rst_n), .start (start_a), .instr (instr),
    .rs1 (rs1), .rs2 (rs2), .imm (imm),
    .busy (busy_a), .done (done_a), .mem_wb_en (wben_a),
    .mem_wb (wb_a), .fault_misaligned (fmis_a),
    .fault_bus (fbus_a), .fault_addr (faddr_a), .bus (bus_a)
  );

  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut_t (
    .clk (clk), .rst_n (rst_n), .start (start_b), .instr (instr),
    .rs1 (rs1), .rs2 (rs2), .imm (imm),
    .busy (busy_b), .done (done_b), .mem_wb_en (wben_b),
    .mem_wb (wb_b), .fault_misaligned (fmis_b),
    .fault_bus (fbus_b), .fault_addr (faddr_b), .bus (bus_b)
  );

  typedef struct {
    rv32i_instr_e op;
    logic [31:0]  rs1;
    logic [31:0]  imm;
    logic [31:0]  rs2;
    logic [31:0]  rdata;
    logic         mis;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic         we;
    logic [31:0]  wdata;
    logic [31:0]  wb;
    logic         wb_en;
  } vec_t;

  vec_t vecs [11];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    instr   = v.op;
    rs1     = v.rs1;
    imm     = v.imm;
    rs2     = v.rs2;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    if (v.mis) begin
      check($sformatf("v%0d done", i), 32'(done_a), 32'd1);
      check($sformatf("v%0d fmis", i), 32'(fmis_a), 32'd1);
      check($sformatf("v%0d faddr", i), faddr_a, v.addr);
      check($sformatf("v%0d noreq", i), 32'(bus_a.mem_req), 32'd0);
      check($sformatf("v%0d wben", i), 32'(wben_a), 32'd0);
      check($sformatf("v%0d wbheld", i), wb_a, v.wb);
      tick();
      check($sformatf("v%0d idle", i), 32'(busy_a), 32'd0);
    end else begin
      check($sformatf("v%0d req", i), 32'(bus_a.mem_req), 32'd1);
      check($sformatf("v%0d addr", i), bus_a.mem_addr, v.addr);
      check($sformatf("v%0d be", i), 32'(bus_a.mem_be), 32'(v.be));
      check($sformatf("v%0d we", i), 32'(bus_a.mem_we), 32'(v.we));
      if (v.we)
        check($sformatf("v%0d wdata", i), bus_a.mem_wdata, v.wdata);
      bus_a.mem_gnt = 1'b1;
      tick();
      bus_a.mem_gnt = 1'b0;
      check($sformatf("v%0d reqdrop", i), 32'(bus_a.mem_req), 32'd0);
      bus_a.mem_rvalid = 1'b1;
      bus_a.mem_rdata  = v.rdata;
      tick();
      bus_a.mem_rvalid = 1'b0;
      check($sformatf("v%0d done", i), 32'(done_a), 32'd1);
      check($sformatf("v%0d wben", i), 32'(wben_a), 32'(v.wb_en));
      check($sformatf("v%0d wb", i), wb_a, v.wb);
      check($sformatf("v%0d flt", i), 32'({fmis_a, fbus_a}), 32'd0);
      tick();
      check($sformatf("v%0d idle", i), 32'({busy_a, done_a}), 32'd0);
    end
  endtask

  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    instr   = I_NOP;
    rs1 = '0; rs2 = '0; imm = '0;
    bus_a.mem_gnt = 1'b0; bus_a.mem_rvalid = 1'b0; bus_a.mem_rdata = '0;
    bus_b.mem_gnt = 1'b0; bus_b.mem_rvalid = 1'b0; bus_b.mem_rdata = '0;

    vecs[0]  = '{I_LB,  32'h100, 32'd3, 32'h0, 32'h80000000,
                 1'b0, 32'h100, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80, 1'b1};
    vecs[1]  = '{I_LHU, 32'h200, 32'd2, 32'h0, 32'hBEEF1234,
                 1'b0, 32'h200, 4'b1100, 1'b0, 32'h0, 32'h0000BEEF, 1'b1};
    vecs[2]  = '{I_LH,  32'h200, 32'd2, 32'h0, 32'hBEEF1234,
                 1'b0, 32'h200, 4'b1100, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b1};
    vecs[3]  = '{I_LW,  32'h400, 32'd0, 32'h0, 32'h12345678,
                 1'b0, 32'h400, 4'b1111, 1'b0, 32'h0, 32'h12345678, 1'b1};
    vecs[4]  = '{I_LBU, 32'h500, 32'd1, 32'h0, 32'h0000A500,
                 1'b0, 32'h500, 4'b0010, 1'b0, 32'h0, 32'h000000A5, 1'b1};
    vecs[5]  = '{I_SW,  32'h600, 32'hFFFFFFFC, 32'hCAFEF00D, 32'hFFFFFFFF,
                 1'b0, 32'h5FC, 4'b1111, 1'b1, 32'hCAFEF00D, 32'hA5, 1'b0};
    vecs[6]  = '{I_SH,  32'h700, 32'd2, 32'h1234ABCD, 32'hFFFFFFFF,
                 1'b0, 32'h700, 4'b1100, 1'b1, 32'hABCDABCD, 32'hA5, 1'b0};
    vecs[7]  = '{I_LW,  32'h100, 32'd2, 32'h0, 32'h0,
                 1'b1, 32'h102, 4'b0000, 1'b0, 32'h0, 32'hA5, 1'b0};
    vecs[8]  = '{I_SH,  32'h100, 32'd1, 32'h0, 32'h0,
                 1'b1, 32'h101, 4'b0000, 1'b0, 32'h0, 32'hA5, 1'b0};
    vecs[9]  = '{I_SB,  32'h100, 32'd1, 32'h11, 32'hFFFFFFFF,
                 1'b0, 32'h100, 4'b0010, 1'b1, 32'h11111111, 32'hA5, 1'b0};
    vecs[10] = '{I_LW,  32'hFFFFFFFC, 32'd8, 32'h0, 32'h0BADF00D,
                 1'b0, 32'h4, 4'b1111, 1'b0, 32'h0, 32'h0BADF00D, 1'b1};

    #2;
    check("rst busy", 32'({busy_a, busy_b}), 32'd0);
    check("rst done", 32'({done_a, done_b}), 32'd0);
    check("rst req", 32'({bus_a.mem_req, bus_b.mem_req}), 32'd0);
    check("rst be", 32'(bus_a.mem_be), 32'd0);
    check("rst wdata", bus_a.mem_wdata, 32'd0);
    check("rst addr", bus_a.mem_addr, 32'd0);
    check("rst wb", wb_a, 32'd0);
    check("rst faddr", faddr_a, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // non-memory instruction is ignored
    instr = I_ADD; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("nonmem busy", 32'(busy_a), 32'd0);
    check("nonmem done", 32'(done_a), 32'd0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // SB with grant withheld for 5 cycles
    instr = I_SB; rs1 = 32'h300; imm = 32'd1; rs2 = 32'hAABBCCDD;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    rs2 = 32'h0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d req", k), 32'(bus_a.mem_req), 32'd1);
      check($sformatf("stall%0d addr", k), bus_a.mem_addr, 32'h300);
      check($sformatf("stall%0d be", k), 32'(bus_a.mem_be), 32'b0010);
      check($sformatf("stall%0d we", k), 32'(bus_a.mem_we), 32'd1);
      check($sformatf("stall%0d wd", k), bus_a.mem_wdata, 32'hDDDDDDDD);
      tick();
    end
    check("stall req5", 32'(bus_a.mem_req), 32'd1);
    bus_a.mem_gnt = 1'b1;
    tick();
    bus_a.mem_gnt = 1'b0;
    check("stall nodone", 32'(done_a), 32'd0);
    tick();
    check("stall waitrv", 32'({busy_a, done_a}), 32'b10);
    bus_a.mem_rvalid = 1'b1; bus_a.mem_rdata = 32'h12121212;
    tick();
    bus_a.mem_rvalid = 1'b0;
    check("stall done", 32'(done_a), 32'd1);
    check("stall wben", 32'(wben_a), 32'd0);
    check("stall wbheld", wb_a, 32'h0BADF00D);
    tick();

    // timeout on the TIMEOUT=4 instance
    instr = I_LW; rs1 = 32'h800; imm = 32'd0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("tmo req%0d", k), 32'(bus_b.mem_req), 32'd1);
      check($sformatf("tmo nodone%0d", k), 32'(done_b), 32'd0);
      tick();
    end
    check("tmo done", 32'(done_b), 32'd1);
    check("tmo fbus", 32'(fbus_b), 32'd1);
    check("tmo fmis", 32'(fmis_b), 32'd0);
    check("tmo wben", 32'(wben_b), 32'd0);
    check("tmo faddr", faddr_b, 32'h800);
    check("tmo reqlow", 32'(bus_b.mem_req), 32'd0);
    tick();
    check("tmo idle", 32'(busy_b), 32'd0);
    bus_b.mem_rvalid = 1'b1;
    tick();
    bus_b.mem_rvalid = 1'b0;
    check("stray done0", 32'(done_b), 32'd0);
    tick();
    check("stray done1", 32'({busy_b, done_b}), 32'd0);

    // start held high while busy: one done, latched op unaffected
    instr = I_LW; rs1 = 32'h900; imm = 32'd0;
    start_a = 1'b1;
    tick();
    instr = I_SW; rs1 = 32'h904;
    check("bsy c1 done", 32'(done_a), 32'd0);
    check("bsy c1 we", 32'(bus_a.mem_we), 32'd0);
    check("bsy c1 addr", bus_a.mem_addr, 32'h900);
    bus_a.mem_gnt = 1'b1;
    tick();
    bus_a.mem_gnt = 1'b0;
    check("bsy c2 done", 32'(done_a), 32'd0);
    bus_a.mem_rvalid = 1'b1; bus_a.mem_rdata = 32'h55AA55AA;
    tick();
    bus_a.mem_rvalid = 1'b0;
    check("bsy c3 done", 32'(done_a), 32'd1);
    check("bsy c3 wb", wb_a, 32'h55AA55AA);
    instr = I_SB; rs1 = 32'h905; rs2 = 32'h7E;
    tick();
    check("bsy c4 done", 32'(done_a), 32'd0);
    check("bsy c4 busy", 32'(busy_a), 32'd0);
    tick();
    start_a = 1'b0;
    check("next c5 req", 32'(bus_a.mem_req), 32'd1);
    check("next c5 be", 32'(bus_a.mem_be), 32'b0010);
    check("next c5 wd", bus_a.mem_wdata, 32'h7E7E7E7E);
    bus_a.mem_gnt = 1'b1;
    tick();
    bus_a.mem_gnt = 1'b0;
    bus_a.mem_rvalid = 1'b1;
    tick();
    bus_a.mem_rvalid = 1'b0;
    check("next done", 32'(done_a), 32'd1);
    tick();

    // asynchronous reset while waiting for the response
    instr = I_LW; rs1 = 32'hA00; imm = 32'd0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    bus_a.mem_gnt = 1'b1;
    tick();
    bus_a.mem_gnt = 1'b0;
    check("rr inresp", 32'({busy_a, bus_a.mem_req}), 32'b10);
    #2 rst_n = 1'b0;
    #1;
    check("rr busy", 32'(busy_a), 32'd0);
    check("rr req", 32'(bus_a.mem_req), 32'd0);
    check("rr wb", wb_a, 32'd0);
    check("rr done", 32'(done_a), 32'd0);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rr nodone%0d", k), 32'({busy_a, done_a}), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
